sensor_select_scanner: RTL and testbench
========================================

Name: sensor_select_scanner

Overview:
- Parametrised successor to the sensor address demultiplexer.
- Converts a sensor address (1..NUM_SENSORS) into a registered one-hot select bus. Address 1 maps to the MSB.
- Adds a valid/ready request handshake, defined handling of invalid addresses, and an autonomous scan mode. Scan mode steps through all sensors and holds each one for DWELL cycles.
- Sits between the sensor-polling controller and the sensor mux/enable lines.

Parameters:
- NUM_SENSORS, 32, number of sensor channels (≥2).
- ADDR_W, 8, address width (2^ADDR_W > NUM_SENSORS).
- DWELL, 4, cycles each sensor stays selected in scan mode (≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  direct-select request is valid.
- req_addr  in  ADDR_W  requested sensor address (1-based).
- req_ready  out  1  block can accept a direct request.
- start_scan  in  1  pulse: begin auto-scan.
- stop_scan  in  1  pulse: abort auto-scan.
- sel  out  NUM_SENSORS  one-hot sensor select.
- sel_addr  out  ADDR_W  address currently selected (0 = none).
- sel_valid  out  1  sel holds exactly one set bit.
- scanning  out  1  FSM is in SCAN.
- scan_wrap  out  1  one-cycle pulse when the scan returns from the last sensor to the first.
- addr_err  out  1  one-cycle pulse on a rejected address or rejected start.

Behaviour:
- Reset: clk and rst fixed as above (single clock, synchronous active-high reset). Every output register clears to 0 and the FSM enters IDLE.
- Mapping: address a, with 1≤a≤NUM_SENSORS, sets sel[NUM_SENSORS-a]; all other bits are 0.
- All outputs are registered. A request accepted at edge k is visible on sel from edge k onward (1-cycle latency).
- FSM states:
  - IDLE: nothing selected.
  - HOLD: a direct selection is held.
  - SCAN: auto-scan is active.
- req_ready = (state != SCAN) && !start_scan (combinational). A request is accepted when req_valid && req_ready.
- Accepted request, valid address: sel, sel_addr and sel_valid are updated; next state is HOLD. A new request in HOLD replaces the selection.
- Accepted request, invalid address (0 or >NUM_SENSORS): sel = 0, sel_addr = 0, sel_valid = 0, addr_err pulses, next state is IDLE.
- start_scan in IDLE or HOLD:
  - Enters SCAN with address 1 selected and the dwell counter at 0.
  - start_scan beats a same-cycle req_valid; that request is not accepted.
- SCAN dwell and advance:
  - The dwell counter increments every cycle.
  - At DWELL-1 the counter resets and the address advances by 1.
  - After address NUM_SENSORS the address wraps to 1, and scan_wrap pulses in the same cycle that sel shows address 1.
- DWELL = 1: the address advances every cycle.
- stop_scan in SCAN: next state is IDLE; sel, sel_addr and sel_valid clear; no scan_wrap pulse.
  - stop_scan beats a same-cycle advance.
  - stop_scan beats a same-cycle start_scan.
- stop_scan outside SCAN is ignored. start_scan in SCAN is ignored (no restart).
- rst mid-scan or mid-hold: all state returns to reset values on the next edge. No pulse outputs fire.
- The dwell counter is $clog2(DWELL) bits wide, with a minimum of 1 bit.
- Address arithmetic is done at ADDR_W width, with the wrap compare against NUM_SENSORS.

Optional Feature:
- Macro: SENSOR_SCAN_MASK_EN.
- With the macro defined:
  - Adds input port scan_mask [NUM_SENSORS-1:0]; bit i enables address i+1.
  - Scan start selects the lowest enabled address. Each advance jumps to the next enabled address above the current one, wrapping, in a single cycle.
  - scan_wrap pulses whenever the advance wraps.
  - start_scan with an all-zero mask: start is rejected, addr_err pulses, state is unchanged.
  - If the mask becomes all-zero during SCAN, the next advance goes to IDLE and pulses addr_err.
  - Mask changes take effect only at an advance.
- Without the macro: all addresses are scanned and the port does not exist.

Decomposition:
- Package sensor_sel_pkg contains:
  - state enum (IDLE, HOLD, SCAN);
  - function addr_to_onehot(addr) returning the MSB-first one-hot;
  - function addr_in_range(addr).
- Sub-module sensor_next_finder: combinational wrap-around priority search that returns the next enabled address after a given one, plus a wrap flag. Instantiated only under SENSOR_SCAN_MASK_EN.

Test Plan:
- Reset with rst=1 for 2 cycles → sel=0, sel_addr=0, all flags 0, req_ready=1.
- Direct addresses 1, 2, 32 → sel = 0x80000000, 0x40000000, 0x00000001 one cycle after acceptance; sel_valid=1; state HOLD.
- req_addr = 0, then 33 → sel=0, one addr_err pulse each, state IDLE. A following address 5 → sel=0x08000000.
- start_scan with DWELL=4 → each address 1..32 is held exactly 4 cycles, scan_wrap pulses once at the return to 1, req_ready=0 throughout. start_scan and req_valid in the same cycle → scan wins.
- stop_scan at address 7, in the same cycle as an advance → IDLE next cycle, sel=0. A separate run with rst asserted mid-scan → reset values, no pulses.
- With SENSOR_SCAN_MASK_EN and mask enabling only addresses 3, 10, 32 → scan sequence 3, 10, 32, 3 with wrap. Mask = 0 at start_scan → addr_err, stays IDLE.

Source files
------------

// File: rtl/sensor_sel_pkg.sv
// Shared types and address helpers for the sensor select scanner.
// Optional feature macro used by the block: SENSOR_SCAN_MASK_EN.
package sensor_sel_pkg;

    // Largest channel count the helpers support. Callers size the result down.
    localparam int unsigned MaxSensors = 256;
    localparam int unsigned MaxIdxW    = $clog2(MaxSensors);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StScan
    } state_e;

    // True when addr names an existing channel (addresses are 1-based).
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned num_sensors);
        return (addr >= 1) && (addr <= num_sensors);
    endfunction

    // MSB-first one-hot: address 1 sets bit num_sensors-1, the last address sets bit 0.
    function automatic logic [MaxSensors-1:0] addr_to_onehot(input int unsigned addr,
                                                            input int unsigned num_sensors);
        logic [MaxSensors-1:0] oh;
        oh = '0;
        if (addr_in_range(addr, num_sensors)) begin
            oh[MaxIdxW'(num_sensors - addr)] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/sensor_select_scanner_if.sv
// Request / select bus between the polling controller (master) and the scanner (slave).
// scan_mask exists only when SENSOR_SCAN_MASK_EN is defined.
interface sensor_select_scanner_if #(
    parameter int unsigned NUM_SENSORS = 32,
    parameter int unsigned ADDR_W      = 8
);
    logic                   req_valid;
    logic [ADDR_W-1:0]      req_addr;
    logic                   req_ready;
    logic                   start_scan;
    logic                   stop_scan;
    logic [NUM_SENSORS-1:0] sel;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_valid;
    logic                   scanning;
    logic                   scan_wrap;
    logic                   addr_err;
`ifdef SENSOR_SCAN_MASK_EN
    logic [NUM_SENSORS-1:0] scan_mask;

    modport master (
        output req_valid, req_addr, start_scan, stop_scan, scan_mask,
        input  req_ready, sel, sel_addr, sel_valid, scanning, scan_wrap, addr_err
    );

    modport slave (
        input  req_valid, req_addr, start_scan, stop_scan, scan_mask,
        output req_ready, sel, sel_addr, sel_valid, scanning, scan_wrap, addr_err
    );
`else
    modport master (
        output req_valid, req_addr, start_scan, stop_scan,
        input  req_ready, sel, sel_addr, sel_valid, scanning, scan_wrap, addr_err
    );

    modport slave (
        input  req_valid, req_addr, start_scan, stop_scan,
        output req_ready, sel, sel_addr, sel_valid, scanning, scan_wrap, addr_err
    );
`endif

endinterface

// File: rtl/sensor_next_finder.sv
// Wrap-around priority search: next enabled address strictly above cur_addr, otherwise the
// lowest enabled address with wrap set. cur_addr = 0 yields the lowest enabled address.
// Used only when SENSOR_SCAN_MASK_EN is defined.
module sensor_next_finder #(
    parameter int unsigned NUM_SENSORS = 32,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic [NUM_SENSORS-1:0] mask,
    input  logic [ADDR_W-1:0]      cur_addr,
    output logic [ADDR_W-1:0]      nxt_addr,
    output logic                   wrap,
    output logic                   found
);

    logic [ADDR_W-1:0] above;
    logic [ADDR_W-1:0] lowest;
    logic              have_above;

    // Descending scan so the last hit is the lowest candidate in each category.
    always_comb begin
        above      = '0;
        lowest     = '0;
        have_above = 1'b0;
        for (int i = int'(NUM_SENSORS); i >= 1; i--) begin
            if (mask[i-1]) begin
                lowest = ADDR_W'(i);
                if (ADDR_W'(i) > cur_addr) begin
                    above      = ADDR_W'(i);
                    have_above = 1'b1;
                end
            end
        end
        found    = |mask;
        wrap     = found && !have_above;
        nxt_addr = have_above ? above : lowest;
    end

endmodule

// File: rtl/sensor_select_scanner.sv
// Sensor address to registered one-hot select, with direct requests and an auto-scan mode.
// Define SENSOR_SCAN_MASK_EN to add scan_mask and skip disabled channels while scanning.
module sensor_select_scanner
    import sensor_sel_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DWELL       = 4
) (
    input logic                    clk,
    input logic                    rst,
    sensor_select_scanner_if.slave bus
);

    localparam int unsigned       CntW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0]   CntLast   = CntW'(DWELL - 1);
    localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(1);

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [NUM_SENSORS-1:0] sel_q;
    logic [ADDR_W-1:0]      sel_addr_q;
    logic                   sel_valid_q;
    logic                   scanning_q;
    logic                   scan_wrap_q;
    logic                   addr_err_q;

    logic [ADDR_W-1:0] start_addr;
    logic              start_ok;
    logic [ADDR_W-1:0] adv_addr;
    logic              adv_ok;
    logic              adv_wrap;

`ifdef SENSOR_SCAN_MASK_EN
    logic [ADDR_W-1:0] find_cur;
    logic [ADDR_W-1:0] find_nxt;
    logic              find_wrap;
    logic              find_any;

    // Outside SCAN the search starts from 0, giving the lowest enabled address for a start.
    assign find_cur = (state_q == StScan) ? sel_addr_q : '0;

    sensor_next_finder #(
        .NUM_SENSORS (NUM_SENSORS),
        .ADDR_W      (ADDR_W)
    ) u_finder (
        .mask     (bus.scan_mask),
        .cur_addr (find_cur),
        .nxt_addr (find_nxt),
        .wrap     (find_wrap),
        .found    (find_any)
    );

    assign start_addr = find_nxt;
    assign start_ok   = find_any;
    assign adv_addr   = find_nxt;
    assign adv_ok     = find_any;
    assign adv_wrap   = find_wrap;
`else
    assign start_addr = AddrFirst;
    assign start_ok   = 1'b1;
    assign adv_wrap   = (sel_addr_q == ADDR_W'(NUM_SENSORS));
    assign adv_addr   = adv_wrap ? AddrFirst : sel_addr_q + AddrFirst;
    assign adv_ok     = 1'b1;
`endif

    // A start in the same cycle outranks a direct request.
    assign bus.req_ready = (state_q != StScan) && !bus.start_scan;

    assign bus.sel       = sel_q;
    assign bus.sel_addr  = sel_addr_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.scanning  = scanning_q;
    assign bus.scan_wrap = scan_wrap_q;
    assign bus.addr_err  = addr_err_q;

    // Control FSM with all outputs registered; scan_wrap and addr_err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            sel_addr_q  <= '0;
            sel_valid_q <= 1'b0;
            scanning_q  <= 1'b0;
            scan_wrap_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            scan_wrap_q <= 1'b0;
            addr_err_q  <= 1'b0;
            unique case (state_q)
                StIdle, StHold: begin
                    if (bus.start_scan) begin
                        if (start_ok) begin
                            state_q     <= StScan;
                            scanning_q  <= 1'b1;
                            cnt_q       <= '0;
                            sel_q       <= NUM_SENSORS'(addr_to_onehot(32'(start_addr),
                                                                       NUM_SENSORS));
                            sel_addr_q  <= start_addr;
                            sel_valid_q <= 1'b1;
                        end else begin
                            // Empty mask: reject the start and keep the current state.
                            addr_err_q <= 1'b1;
                        end
                    end else if (bus.req_valid) begin
                        if (addr_in_range(32'(bus.req_addr), NUM_SENSORS)) begin
                            state_q     <= StHold;
                            sel_q       <= NUM_SENSORS'(addr_to_onehot(32'(bus.req_addr),
                                                                       NUM_SENSORS));
                            sel_addr_q  <= bus.req_addr;
                            sel_valid_q <= 1'b1;
                        end else begin
                            state_q     <= StIdle;
                            sel_q       <= '0;
                            sel_addr_q  <= '0;
                            sel_valid_q <= 1'b0;
                            addr_err_q  <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (bus.stop_scan) begin
                        state_q     <= StIdle;
                        scanning_q  <= 1'b0;
                        cnt_q       <= '0;
                        sel_q       <= '0;
                        sel_addr_q  <= '0;
                        sel_valid_q <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (adv_ok) begin
                            sel_q       <= NUM_SENSORS'(addr_to_onehot(32'(adv_addr),
                                                                       NUM_SENSORS));
                            sel_addr_q  <= adv_addr;
                            scan_wrap_q <= adv_wrap;
                        end else begin
                            // Mask emptied while scanning: drop out at the advance.
                            state_q     <= StIdle;
                            scanning_q  <= 1'b0;
                            sel_q       <= '0;
                            sel_addr_q  <= '0;
                            sel_valid_q <= 1'b0;
                            addr_err_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_select_scanner.sv
// Self-checking bench for sensor_select_scanner: table-driven direct requests through a
// scoreboard queue, then hand-written scan, stop and reset sequences.
// Mask sequences are included when SENSOR_SCAN_MASK_EN is defined.
module tb_sensor_select_scanner;

    localparam int unsigned NS = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 4;

    logic clk = 1'b0;
    logic rst;

    sensor_select_scanner_if #(.NUM_SENSORS(NS), .ADDR_W(AW)) bus ();

    sensor_select_scanner #(
        .NUM_SENSORS (NS),
        .ADDR_W      (AW),
        .DWELL       (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        vld;
        logic [7:0]  addr;
        logic [31:0] sel;
        logic [7:0]  sel_addr;
        logic        sel_valid;
        logic        err;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_sel(input int a);
        logic [31:0] one;
        one = 32'h1;
        if (a >= 1 && a <= int'(NS)) return one << (int'(NS) - a);
        return 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        int   m_addr;
        int   m_cnt;
        int   wraps;
        logic m_wrap;
        logic done;

        //          vld   addr   sel           sel_addr valid err
        vecs[0]  = '{1'b1, 8'd1,   32'h8000_0000, 8'd1,  1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'd2,   32'h4000_0000, 8'd2,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'd7,   32'h4000_0000, 8'd2,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'd32,  32'h0000_0001, 8'd32, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'd0,   32'h0000_0000, 8'd0,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'd0,   32'h0000_0000, 8'd0,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd33,  32'h0000_0000, 8'd0,  1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'd5,   32'h0800_0000, 8'd5,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'd17,  32'h0000_8000, 8'd17, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'd255, 32'h0000_0000, 8'd0,  1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'd16,  32'h0001_0000, 8'd16, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'd16,  32'h0001_0000, 8'd16, 1'b1, 1'b0};

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.start_scan = 1'b0;
        bus.stop_scan  = 1'b0;
`ifdef SENSOR_SCAN_MASK_EN
        bus.scan_mask  = '1;
`endif

        // Reset held for two edges.
        tick();
        tick();
        chk("reset_sel", bus.sel, 32'h0);
        chk("reset_sel_addr", bus.sel_addr, 32'h0);
        chk("reset_sel_valid", bus.sel_valid, 32'h0);
        chk("reset_scanning", bus.scanning, 32'h0);
        chk("reset_scan_wrap", bus.scan_wrap, 32'h0);
        chk("reset_addr_err", bus.addr_err, 32'h0);
        chk("reset_req_ready", bus.req_ready, 32'h1);
        rst = 1'b0;

        // Direct requests through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = vecs[i].vld;
            bus.req_addr  = vecs[i].addr;
            exp_q.push_back(vecs[i]);
            #1;
            chk("direct_req_ready", bus.req_ready, 32'h1);
            tick();
            e = exp_q.pop_front();
            chk("direct_sel", bus.sel, e.sel);
            chk("direct_sel_addr", bus.sel_addr, 32'(e.sel_addr));
            chk("direct_sel_valid", bus.sel_valid, 32'(e.sel_valid));
            chk("direct_addr_err", bus.addr_err, 32'(e.err));
            chk("direct_scanning", bus.scanning, 32'h0);
        end

        // start_scan and req_valid together: scan wins.
        bus.start_scan = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 8'd9;
        #1;
        chk("ready_low_on_start", bus.req_ready, 32'h0);
        tick();
        bus.start_scan = 1'b0;
        chk("scan_start_addr", bus.sel_addr, 32'd1);
        chk("scan_start_sel", bus.sel, 32'h8000_0000);
        chk("scan_start_scanning", bus.scanning, 32'h1);
        chk("scan_start_valid", bus.sel_valid, 32'h1);

        // Full scan with the request held high, a stray restart, and a wrap.
        m_addr = 1;
        m_cnt  = 0;
        wraps  = 0;
        done   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wraps == 1 && m_addr == 7 && m_cnt == int'(DW) - 1) begin
                done = 1'b1;
                break;
            end
            bus.start_scan = (i == 10);
            #1;
            chk("scan_req_ready", bus.req_ready, 32'h0);
            tick();
            if (m_cnt == int'(DW) - 1) begin
                m_cnt  = 0;
                m_wrap = (m_addr == int'(NS));
                m_addr = m_wrap ? 1 : m_addr + 1;
            end else begin
                m_cnt++;
                m_wrap = 1'b0;
            end
            if (m_wrap) wraps++;
            chk("scan_addr", bus.sel_addr, 32'(m_addr));
            chk("scan_sel", bus.sel, model_sel(m_addr));
            chk("scan_wrap", bus.scan_wrap, 32'(m_wrap));
        end
        bus.start_scan = 1'b0;
        chk("scan_reached_addr7", 32'(done), 32'h1);
        chk("scan_wrap_count", 32'(wraps), 32'h1);

        // stop_scan on an advance cycle, together with start_scan.
        bus.req_valid  = 1'b0;
        bus.stop_scan  = 1'b1;
        bus.start_scan = 1'b1;
        tick();
        bus.stop_scan  = 1'b0;
        bus.start_scan = 1'b0;
        chk("stop_sel", bus.sel, 32'h0);
        chk("stop_sel_addr", bus.sel_addr, 32'h0);
        chk("stop_sel_valid", bus.sel_valid, 32'h0);
        chk("stop_scanning", bus.scanning, 32'h0);
        chk("stop_scan_wrap", bus.scan_wrap, 32'h0);

        // stop_scan outside SCAN is ignored.
        bus.stop_scan = 1'b1;
        tick();
        bus.stop_scan = 1'b0;
        chk("idle_stop_scanning", bus.scanning, 32'h0);
        chk("idle_stop_sel", bus.sel, 32'h0);
        chk("idle_stop_req_ready", bus.req_ready, 32'h1);

        // Reset in the middle of a scan.
        bus.start_scan = 1'b1;
        tick();
        bus.start_scan = 1'b0;
        repeat (5) tick();
        chk("midscan_addr", bus.sel_addr, 32'd2);
        rst = 1'b1;
        tick();
        chk("midrst_sel", bus.sel, 32'h0);
        chk("midrst_sel_addr", bus.sel_addr, 32'h0);
        chk("midrst_sel_valid", bus.sel_valid, 32'h0);
        chk("midrst_scanning", bus.scanning, 32'h0);
        chk("midrst_scan_wrap", bus.scan_wrap, 32'h0);
        chk("midrst_addr_err", bus.addr_err, 32'h0);
        chk("midrst_req_ready", bus.req_ready, 32'h1);
        rst = 1'b0;
        tick();
        chk("post_rst_scanning", bus.scanning, 32'h0);
        chk("post_rst_sel", bus.sel, 32'h0);

        // Direct request after reset, leaves the block in HOLD at address 32.
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'd32;
        tick();
        bus.req_valid = 1'b0;
        chk("post_rst_direct_sel", bus.sel, 32'h0000_0001);

`ifdef SENSOR_SCAN_MASK_EN
        begin
            int exp_seq[4];
            int exp_wrap[4];
            exp_seq  = '{3, 10, 32, 3};
            exp_wrap = '{0, 0, 0, 1};

            // Empty mask: start rejected, HOLD kept.
            bus.scan_mask  = '0;
            bus.start_scan = 1'b1;
            tick();
            bus.start_scan = 1'b0;
            chk("mask0_addr_err", bus.addr_err, 32'h1);
            chk("mask0_scanning", bus.scanning, 32'h0);
            chk("mask0_sel_addr", bus.sel_addr, 32'd32);

            bus.scan_mask  = 32'h8000_0204;
            bus.start_scan = 1'b1;
            tick();
            bus.start_scan = 1'b0;
            chk("mask_start_addr", bus.sel_addr, 32'(exp_seq[0]));
            chk("mask_start_scanning", bus.scanning, 32'h1);
            for (int k = 1; k < 4; k++) begin
                repeat (DW) tick();
                chk("mask_seq_addr", bus.sel_addr, 32'(exp_seq[k]));
                chk("mask_seq_sel", bus.sel, model_sel(exp_seq[k]));
                chk("mask_seq_wrap", bus.scan_wrap, 32'(exp_wrap[k]));
            end

            // Mask emptied mid-scan: next advance drops to IDLE with an error.
            bus.scan_mask = '0;
            repeat (DW) tick();
            chk("mask_empty_scanning", bus.scanning, 32'h0);
            chk("mask_empty_err", bus.addr_err, 32'h1);
            chk("mask_empty_sel", bus.sel, 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
